main_mem_harness: RTL and testbench
===================================

# main_mem_harness

Synthesizable run controller that sits directly upstream of the HLS-generated `main` core (bsort100 flow) and drives its slave memory interface and start/done handshake. It streams NWORDS 32-bit input words into `main`'s internal array through the slave RAM port, pulses `start_port`, counts cycles until `done_port`, then reads the sorted array back and streams it out. It replaces the file-driven stimulus of simulation with a hardware path usable on the Artix-7 board.

## Interface
- NWORDS, 100, array length in 32-bit words
- BASE_ADDR, 0, byte address of the array inside `main`'s slave RAM space
- ADDR_W, 9, slave address width per channel (S_addr_ram is 2*ADDR_W)
- DATA_W, 64, slave data width per channel (S_Wdata_ram/Sout_Rdata_ram are 2*DATA_W)
- SIZE_W, 7, access-size width per channel (S_data_ram_size is 2*SIZE_W)
- TIMEOUT, 200000000, maximum run cycles before abort
- Clock and reset are decided as follows: one clock; reset is asynchronous and active-low.
- clock  in  1  single clock for the whole block
- reset  in  1  asynchronous, active-low reset
- in_valid / in_ready  in / out  1 / 1  input word handshake
- in_data  in  32  input word
- out_valid / out_ready  out / in  1 / 1  output word handshake
- out_data  out  32  sorted word
- out_last  out  1  high with word NWORDS-1
- run_cycles  out  32  cycles of the last run
- run_status  out  2  0 idle, 1 busy, 2 done, 3 timeout
- start_port  out  1  to `main`
- done_port  in  1  from `main`
- S_oe_ram, S_we_ram  out  2  slave read/write enables, channel 0 only used
- S_addr_ram  out  2*ADDR_W  slave address
- S_Wdata_ram  out  2*DATA_W  slave write data
- S_data_ram_size  out  2*SIZE_W  access size in bits
- Sout_Rdata_ram  in  2*DATA_W  slave read data
- Sout_DataRdy  in  2  slave access acknowledge

## Operation
- States: IDLE, LOAD, WR_WAIT, START, RUN, RD_REQ, RD_WAIT, OUT, TMO.
- IDLE: in_ready=1; first in_valid&in_ready → write word 0, go WR_WAIT.
- LOAD/WR_WAIT: each accepted word issues S_we_ram[0]=1, S_addr_ram[ADDR_W-1:0]=BASE_ADDR+4*idx, S_Wdata_ram[31:0]=in_data (upper bits 0), S_data_ram_size[SIZE_W-1:0]=32; held stable until Sout_DataRdy[0]; in_ready=0 while pending. After word NWORDS-1 is acknowledged → START.
- START: start_port=1 exactly one cycle; counter:=1 → RUN.
- RUN: counter increments each cycle; done_port=1 → run_cycles:=counter, RD_REQ. Counter reaching TIMEOUT → TMO.
- RD_REQ/RD_WAIT: S_oe_ram[0]=1, address BASE_ADDR+4*idx, size 32, held until Sout_DataRdy[0]; capture Sout_Rdata_ram[31:0] → OUT.
- OUT: out_valid=1 holding captured word until out_ready; then idx+1 → RD_REQ, or after NWORDS-1 → IDLE, run_status=2.
- TMO: run_status=3, start_port=0, all enables 0; sticky until reset.
- Channel 1 enables, address, data, size always 0.

## Timing
- Reset values: all outputs 0, except run_status=0; idx=0, counter=0.
- Slave request asserted in the cycle after the accepting handshake; DataRdy in the same cycle as the request is accepted (zero-wait slave).
- run_cycles counts from the start_port cycle through the cycle done_port is sampled high, inclusive; done_port already high in START cycle is ignored.
- done_port coinciding with TIMEOUT: done wins.
- out_ready low: data/valid/last held unchanged.
- Reset mid-run: immediate return to IDLE, start_port and enables drop asynchronously; `main` is reset in parallel by the board.
- in_valid during RUN/OUT: ignored, in_ready=0.

## Structure
- Package main_harness_pkg: state enum, run_status codes, channel-0 slicing constants, WORD_BYTES=4, SIZE_32=32.
- Sub-module main_slave_port: channel-0 request/hold/acknowledge sequencer (rd/wr request in, ack and read word out); FSM and counters stay in the top.

## Test plan
- Load 100 words 99..0, zero-wait slave, done 5000 cycles after start → output 0..99 in order, out_last on 100th, run_status=2, run_cycles=5001.
- Slave DataRdy delayed 3 cycles per access → addresses/data held stable for 4 cycles each, no word lost.
- out_ready toggling 1-in-3 → output sequence identical, out_data stable while stalled.
- done_port never asserted, TIMEOUT=1000 → run_status=3 at cycle 1000, start_port and enables 0, no output.
- Reset asserted during RUN at cycle 200 → all outputs 0 next edge, new load accepted after release.
- done_port held high during START → ignored; completes on later done, run_cycles correct.

Source files
------------

// File: rtl/main_harness_pkg.sv
// Shared types and constants for the `main` run controller and its slave-port sequencer.
package main_harness_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_WR_WAIT,
        S_START,
        S_RUN,
        S_RD_REQ,
        S_RD_WAIT,
        S_OUT,
        S_TMO
    } state_e;

    typedef enum logic [1:0] {
        RUN_IDLE    = 2'd0,
        RUN_BUSY    = 2'd1,
        RUN_DONE    = 2'd2,
        RUN_TIMEOUT = 2'd3
    } run_status_e;

    // Only channel 0 of the dual-channel slave bus is driven; it occupies the low slice.
    localparam int WORD_W     = 32;
    localparam int WORD_BYTES = 4;
    localparam int SIZE_32    = 32;

endpackage

// File: rtl/main_slave_port.sv
// Channel-0 sequencer for `main`'s slave RAM port: registers one read or write request
// and holds it stable until the slave acknowledges it.
module main_slave_port
    import main_harness_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 64,
    parameter int SIZE_W = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_rd,
    input  logic                  req_wr,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [WORD_W-1:0]     req_wdata,
    output logic                  ack,
    output logic [WORD_W-1:0]     rd_word,
    output logic [1:0]            S_oe_ram,
    output logic [1:0]            S_we_ram,
    output logic [2*ADDR_W-1:0]   S_addr_ram,
    output logic [2*DATA_W-1:0]   S_Wdata_ram,
    output logic [2*SIZE_W-1:0]   S_data_ram_size,
    input  logic [2*DATA_W-1:0]   Sout_Rdata_ram,
    input  logic [1:0]            Sout_DataRdy
);

    logic              oe_q, oe_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              pending;
    logic              unused_slave_bits;

    assign pending = oe_q | we_q;
    assign ack     = pending & Sout_DataRdy[0];
    assign rd_word = Sout_Rdata_ram[WORD_W-1:0];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        oe_d    = oe_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (ack) begin
            oe_d    = 1'b0;
            we_d    = 1'b0;
            addr_d  = '0;
            wdata_d = '0;
        end else if (!pending && (req_rd || req_wr)) begin
            oe_d    = req_rd;
            we_d    = req_wr;
            addr_d  = req_addr;
            wdata_d = req_wr ? req_wdata : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            oe_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            oe_q    <= oe_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign S_oe_ram        = {1'b0, oe_q};
    assign S_we_ram        = {1'b0, we_q};
    assign S_addr_ram      = {{ADDR_W{1'b0}}, addr_q};
    assign S_Wdata_ram     = {{(2*DATA_W-WORD_W){1'b0}}, wdata_q};
    assign S_data_ram_size = {{SIZE_W{1'b0}}, pending ? SIZE_W'(SIZE_32) : {SIZE_W{1'b0}}};

    // Upper read-data bits and the channel-1 acknowledge carry nothing for this array.
    assign unused_slave_bits = ^{Sout_Rdata_ram[2*DATA_W-1:WORD_W], Sout_DataRdy[1]};

endmodule

// File: rtl/main_mem_harness.sv
// Run controller for the HLS `main` core: loads the array through the slave RAM port,
// pulses start, times the run until done, then streams the sorted array back out.
module main_mem_harness
    import main_harness_pkg::*;
#(
    parameter int          NWORDS    = 100,
    parameter int          BASE_ADDR = 0,
    parameter int          ADDR_W    = 9,
    parameter int          DATA_W    = 64,
    parameter int          SIZE_W    = 7,
    parameter int unsigned TIMEOUT   = 200000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_W-1:0]     in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_W-1:0]     out_data,
    output logic                  out_last,
    output logic [31:0]           run_cycles,
    output logic [1:0]            run_status,
    output logic                  start_port,
    input  logic                  done_port,
    output logic [1:0]            S_oe_ram,
    output logic [1:0]            S_we_ram,
    output logic [2*ADDR_W-1:0]   S_addr_ram,
    output logic [2*DATA_W-1:0]   S_Wdata_ram,
    output logic [2*SIZE_W-1:0]   S_data_ram_size,
    input  logic [2*DATA_W-1:0]   Sout_Rdata_ram,
    input  logic [1:0]            Sout_DataRdy
);

    localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    state_e            state_q, state_d;
    run_status_e       run_status_q, run_status_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [31:0]       counter_q, counter_d;
    logic [31:0]       run_cycles_q, run_cycles_d;
    logic              in_ready_q, in_ready_d;
    logic              start_port_q, start_port_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic [WORD_W-1:0] out_data_q, out_data_d;

    logic              req_rd, req_wr, port_ack, last_idx;
    logic [ADDR_W-1:0] req_addr;
    logic [WORD_W-1:0] rd_word;

    function automatic logic [ADDR_W-1:0] word_addr(input logic [IDX_W-1:0] idx);
        return ADDR_W'(BASE_ADDR + WORD_BYTES * int'(idx));
    endfunction

    assign last_idx = (idx_q == IDX_W'(NWORDS - 1));
    assign req_addr = word_addr(idx_q);

    always_comb begin
        state_d      = state_q;
        run_status_d = run_status_q;
        idx_d        = idx_q;
        counter_d    = counter_q;
        run_cycles_d = run_cycles_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_data_d   = out_data_q;
        req_rd       = 1'b0;
        req_wr       = 1'b0;

        unique case (state_q)
            S_IDLE, S_LOAD: begin
                if (in_valid && in_ready_q) begin
                    req_wr       = 1'b1;
                    run_status_d = RUN_BUSY;
                    state_d      = S_WR_WAIT;
                end
            end
            S_WR_WAIT: begin
                if (port_ack) begin
                    if (last_idx) begin
                        idx_d     = '0;
                        counter_d = 32'd1;
                        state_d   = S_START;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_LOAD;
                    end
                end
            end
            // done_port is deliberately not sampled here: a stale done from the previous run is ignored.
            S_START: begin
                counter_d = counter_q + 32'd1;
                state_d   = S_RUN;
            end
            S_RUN: begin
                if (done_port) begin
                    run_cycles_d = counter_q;
                    state_d      = S_RD_REQ;
                end else if (counter_q >= TIMEOUT) begin
                    run_status_d = RUN_TIMEOUT;
                    state_d      = S_TMO;
                end else begin
                    counter_d = counter_q + 32'd1;
                end
            end
            S_RD_REQ: begin
                req_rd  = 1'b1;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (port_ack) begin
                    out_data_d  = rd_word;
                    out_valid_d = 1'b1;
                    out_last_d  = last_idx;
                    state_d     = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (last_idx) begin
                        idx_d        = '0;
                        run_status_d = RUN_DONE;
                        state_d      = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_RD_REQ;
                    end
                end
            end
            S_TMO: begin
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d   = (state_d == S_IDLE) || (state_d == S_LOAD);
        start_port_d = (state_d == S_START);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            run_status_q <= RUN_IDLE;
            idx_q        <= '0;
            counter_q    <= '0;
            run_cycles_q <= '0;
            in_ready_q   <= 1'b0;
            start_port_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            run_status_q <= run_status_d;
            idx_q        <= idx_d;
            counter_q    <= counter_d;
            run_cycles_q <= run_cycles_d;
            in_ready_q   <= in_ready_d;
            start_port_q <= start_port_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_data_q   <= out_data_d;
        end
    end

    main_slave_port #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .SIZE_W (SIZE_W)
    ) u_slave_port (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_rd          (req_rd),
        .req_wr          (req_wr),
        .req_addr        (req_addr),
        .req_wdata       (in_data),
        .ack             (port_ack),
        .rd_word         (rd_word),
        .S_oe_ram        (S_oe_ram),
        .S_we_ram        (S_we_ram),
        .S_addr_ram      (S_addr_ram),
        .S_Wdata_ram     (S_Wdata_ram),
        .S_data_ram_size (S_data_ram_size),
        .Sout_Rdata_ram  (Sout_Rdata_ram),
        .Sout_DataRdy    (Sout_DataRdy)
    );

    assign in_ready   = in_ready_q;
    assign start_port = start_port_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign out_data   = out_data_q;
    assign run_cycles = run_cycles_q;
    assign run_status = run_status_q;

endmodule

// File: tb/tb_main_mem_harness.sv
// Directed bench for main_mem_harness with a behavioural slave RAM and a sorting `main` stand-in.
module tb_main_mem_harness;

    localparam int          NWORDS    = 100;
    localparam int          BASE_ADDR = 0;
    localparam int          ADDR_W    = 9;
    localparam int          DATA_W    = 64;
    localparam int          SIZE_W    = 7;
    localparam int unsigned TIMEOUT   = 6000;

    logic                  clk   = 1'b0;
    logic                  rst_n = 1'b1;
    logic                  in_valid, in_ready, out_valid, out_ready, out_last;
    logic                  start_port, done_port;
    logic [31:0]           in_data, out_data, run_cycles;
    logic [1:0]            run_status, S_oe_ram, S_we_ram, Sout_DataRdy;
    logic [2*ADDR_W-1:0]   S_addr_ram;
    logic [2*DATA_W-1:0]   S_Wdata_ram, Sout_Rdata_ram;
    logic [2*SIZE_W-1:0]   S_data_ram_size;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    main_mem_harness #(
        .NWORDS (NWORDS), .BASE_ADDR (BASE_ADDR), .ADDR_W (ADDR_W),
        .DATA_W (DATA_W), .SIZE_W (SIZE_W), .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .in_valid (in_valid), .in_ready (in_ready), .in_data (in_data),
        .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data), .out_last (out_last),
        .run_cycles (run_cycles), .run_status (run_status),
        .start_port (start_port), .done_port (done_port),
        .S_oe_ram (S_oe_ram), .S_we_ram (S_we_ram), .S_addr_ram (S_addr_ram),
        .S_Wdata_ram (S_Wdata_ram), .S_data_ram_size (S_data_ram_size),
        .Sout_Rdata_ram (Sout_Rdata_ram), .Sout_DataRdy (Sout_DataRdy)
    );

    // Slave RAM model with a programmable acknowledge delay; sorts itself when `main` is started.
    int              slv_delay = 0;
    int              slv_cnt   = 0;
    int              wr_count  = 0;
    int              rd_count  = 0;
    int              hold_bad  = 0;
    logic            prev_pend = 1'b0;
    logic [3:0]      prev_en   = '0;
    logic [ADDR_W-1:0] prev_addr  = '0;
    logic [31:0]     prev_wdata = '0;
    logic [31:0]     mem [128];

    wire             req_pend = S_we_ram[0] | S_oe_ram[0];
    wire [ADDR_W-1:0] slv_addr = S_addr_ram[ADDR_W-1:0];

    assign Sout_DataRdy   = {1'b0, req_pend && (slv_cnt == slv_delay)};
    assign Sout_Rdata_ram = {64'hDEAD_BEEF_0BAD_F00D, 32'hFFFF_FFFF, mem[slv_addr[ADDR_W-1:2]]};

    always @(posedge clk) begin : slave_model
        logic [31:0] t [128];
        logic [31:0] tmp;
        if (prev_pend && (!req_pend || {S_oe_ram, S_we_ram} != prev_en ||
                          slv_addr != prev_addr || S_Wdata_ram[31:0] != prev_wdata))
            hold_bad <= hold_bad + 1;
        prev_pend  <= req_pend && !Sout_DataRdy[0];
        prev_en    <= {S_oe_ram, S_we_ram};
        prev_addr  <= slv_addr;
        prev_wdata <= S_Wdata_ram[31:0];
        if (req_pend) begin
            if (Sout_DataRdy[0]) begin
                slv_cnt <= 0;
                if (S_we_ram[0]) begin
                    mem[slv_addr[ADDR_W-1:2]] <= S_Wdata_ram[31:0];
                    wr_count <= wr_count + 1;
                end else begin
                    rd_count <= rd_count + 1;
                end
            end else begin
                slv_cnt <= slv_cnt + 1;
            end
        end
        if (start_port) begin
            for (int i = 0; i < 128; i++) t[i] = mem[i];
            for (int p = 0; p < NWORDS - 1; p++)
                for (int j = BASE_ADDR / 4; j < BASE_ADDR / 4 + NWORDS - 1 - p; j++)
                    if (t[j] > t[j+1]) begin
                        tmp = t[j]; t[j] = t[j+1]; t[j+1] = tmp;
                    end
            for (int i = 0; i < 128; i++) mem[i] <= t[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] gen_word(input int pat, input int i);
        case (pat)
            0:       return 32'(NWORDS - 1 - i);
            1:       return 32'hF000_0000 + 32'(NWORDS - 1 - i);
            2:       return 32'(((i * 37) % NWORDS) * 3 + 7);
            default: return 32'h8000_0000 + 32'(i * 5);
        endcase
    endfunction

    function automatic logic [31:0] exp_word(input int pat, input int k);
        case (pat)
            0:       return 32'(k);
            1:       return 32'hF000_0000 + 32'(k);
            2:       return 32'(k * 3 + 7);
            default: return 32'h8000_0000 + 32'(k * 5);
        endcase
    endfunction

    task automatic send_word(input logic [31:0] w);
        int t = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("in_ready_wait", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic load_words(input int pat);
        for (int i = 0; i < NWORDS; i++) begin
            send_word(gen_word(pat, i));
            check("wr_addr", 32'(S_addr_ram), 32'(BASE_ADDR + 4 * i));
            check("wr_data", S_Wdata_ram[31:0], gen_word(pat, i));
            if (i == 0) begin
                check("wr_we", 32'(S_we_ram), 32'd1);
                check("wr_oe", 32'(S_oe_ram), 32'd0);
                check("wr_size", 32'(S_data_ram_size), 32'd32);
                check("wr_data_hi", 32'(|S_Wdata_ram[2*DATA_W-1:32]), 32'd0);
                check("in_ready_pending", 32'(in_ready), 32'd0);
            end
        end
    endtask

    task automatic wait_start();
        int t = 0;
        while (start_port !== 1'b1 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("start_seen", 32'(start_port), 32'd1);
    endtask

    task automatic run_main(input int done_at, input bit done_in_start);
        wait_start();
        if (done_in_start) done_port = 1'b1;
        @(negedge clk);
        done_port = 1'b0;
        check("start_pulse", 32'(start_port), 32'd0);
        check("status_busy", 32'(run_status), 32'd1);
        in_valid = 1'b1;
        in_data  = 32'hBAD0_BAD0;
        repeat (done_at - 1) @(negedge clk);
        check("in_ready_run", 32'(in_ready), 32'd0);
        in_valid  = 1'b0;
        done_port = 1'b1;
        @(negedge clk);
        done_port = 1'b0;
    endtask

    task automatic read_out(input int pat, input bit stall);
        int          got = 0;
        int          cyc = 0;
        int          stall_bad = 0;
        bit          stalled = 1'b0;
        logic [31:0] held_d = '0;
        logic        held_l = 1'b0;
        while (got < NWORDS && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (stalled && (out_valid !== 1'b1 || out_data !== held_d || out_last !== held_l))
                stall_bad++;
            stalled   = 1'b0;
            out_ready = stall ? (cyc % 3 == 0) : 1'b1;
            if (out_valid === 1'b1) begin
                if (out_ready) begin
                    check("out_data", out_data, exp_word(pat, got));
                    check("out_last", 32'(out_last), 32'(got == NWORDS - 1));
                    got++;
                end else begin
                    stalled = 1'b1;
                    held_d  = out_data;
                    held_l  = out_last;
                end
            end
        end
        @(negedge clk);
        out_ready = 1'b0;
        check("out_count", 32'(got), 32'(NWORDS));
        check("stall_hold", 32'(stall_bad), 32'd0);
    endtask

    task automatic full_run(input int pat, input int done_at, input bit stall, input bit done_in_start);
        int w0 = wr_count;
        int r0 = rd_count;
        int h0 = hold_bad;
        load_words(pat);
        run_main(done_at, done_in_start);
        read_out(pat, stall);
        check("status_done", 32'(run_status), 32'd2);
        check("run_cycles", run_cycles, 32'(done_at + 1));
        check("out_valid_idle", 32'(out_valid), 32'd0);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        check("wr_count", 32'(wr_count - w0), 32'(NWORDS));
        check("rd_count", 32'(rd_count - r0), 32'(NWORDS));
        check("slave_hold", 32'(hold_bad - h0), 32'd0);
    endtask

    task automatic check_quiet_outputs(input string tag);
        check({tag, "_start"}, 32'(start_port), 32'd0);
        check({tag, "_we"}, 32'(S_we_ram), 32'd0);
        check({tag, "_oe"}, 32'(S_oe_ram), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        done_port = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);

        check_quiet_outputs("rst");
        check("rst_status", 32'(run_status), 32'd0);
        check("rst_run_cycles", run_cycles, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_addr", 32'(S_addr_ram), 32'd0);
        check("rst_size", 32'(S_data_ram_size), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("idle_status", 32'(run_status), 32'd0);

        // Zero-wait slave, descending input, long run.
        slv_delay = 0;
        full_run(0, 5000, 1'b0, 1'b0);

        // Slow slave: every access waits three extra cycles.
        slv_delay = 3;
        full_run(1, 20, 1'b0, 1'b0);

        // Back-pressured output and a stale done during the start pulse.
        slv_delay = 0;
        full_run(2, 300, 1'b1, 1'b1);

        // Core never finishes: abort exactly at the limit.
        load_words(3);
        wait_start();
        repeat (TIMEOUT - 1) @(negedge clk);
        check("tmo_status_before", 32'(run_status), 32'd1);
        in_valid = 1'b1;
        in_data  = 32'h1234_5678;
        @(negedge clk);
        check("tmo_status", 32'(run_status), 32'd3);
        check_quiet_outputs("tmo");
        repeat (5) @(negedge clk);
        check("tmo_sticky", 32'(run_status), 32'd3);
        check_quiet_outputs("tmo_late");
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("tmo_rst_status", 32'(run_status), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset in the middle of a run, then a complete fresh run.
        load_words(0);
        wait_start();
        repeat (200) @(negedge clk);
        check("mid_status_busy", 32'(run_status), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_quiet_outputs("mid_rst");
        check("mid_rst_status", 32'(run_status), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        full_run(2, 50, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
